// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder controller.
// Holds the controller state encoding and the widest supported operand.
package serial_adder_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/half_adder.sv
// 1-bit half adder; two of these plus an OR form the serial full-adder cell.
// Latency: combinational. Backpressure: none.
// Pure combinational cell, no flow control.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: sums two WIDTH-bit operands plus carry-in, LSB first, one bit per cycle.
// Latency: operands accepted at edge T, result valid from edge T+WIDTH.
// Backpressure: result held in S_DONE until out_ready; no new operands are taken until then.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    // Holds the WIDTH-1 most recent sum bits; the final bit is merged in on the last edge.
    logic [WIDTH-2:0]   res_sh;
    logic [WIDTH-1:0]   res_nxt;
    logic               c_reg;
    logic [CNT_W-1:0]   cnt;

    logic               ha0_sum;
    logic               ha0_carry;
    logic               ha1_sum;
    logic               ha1_carry;
    logic               s_bit;
    logic               c_next;

    logic               start;
    logic               last_bit;

    half_adder u_ha0 (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    half_adder u_ha1 (
        .a     (ha0_sum),
        .b     (c_reg),
        .sum   (ha1_sum),
        .carry (ha1_carry)
    );

    assign s_bit    = ha1_sum;
    assign c_next   = ha0_carry | ha1_carry;
    assign res_nxt  = {s_bit, res_sh};
    assign start    = in_valid && in_ready;
    assign last_bit = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // in_ready is a pure state decode so it never combinationally depends on in_valid.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE:  in_ready  = !rst;
            S_RUN:   busy      = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            c_reg  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        c_reg  <= cin;
                        cnt    <= '0;
                        res_sh <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= res_nxt[WIDTH-1:1];
                    c_reg  <= c_next;
                    if (last_bit) begin
                        // Park the counter at zero so it never runs past WIDTH-1.
                        cnt  <= '0;
                        sum  <= res_nxt;
                        cout <= c_next;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of serial_adder_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [7:0] a, b, sum;

    logic       in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2, busy2;
    logic [1:0] a2, b2, sum2;

    int checks   = 0;
    int failures = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .busy(busy2)
    );

    // Drives one operation on the WIDTH=8 instance; lat counts edges from accept to out_valid.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                       input int gap, input int rdly, input bit toggle,
                       output logic [7:0] rs, output logic rc, output int lat,
                       output bit saw_ready);
        repeat (gap) @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        lat       = 0;
        saw_ready = in_ready;
        while (!out_valid && lat < 40) begin
            if (toggle) begin
                a = ~a; b = ~b; cin = ~cin;
            end
            @(negedge clk);
            lat++;
            if (in_ready) saw_ready = 1'b1;
        end
        repeat (rdly) @(negedge clk);
        rs = sum; rc = cout;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic op2(input logic [1:0] ta, input logic [1:0] tb_, input logic tc,
                       input int gap, input int rdly,
                       output logic [1:0] rs, output logic rc, output int lat);
        repeat (gap) @(negedge clk);
        for (int i = 0; i < 50 && !in_ready2; i++) @(negedge clk);
        a2 = ta; b2 = tb_; cin2 = tc; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        repeat (rdly) @(negedge clk);
        rs = sum2; rc = cout2;
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== 8'h00 || cout !== 1'b0) begin failures++; $display("FAIL reset_result: got %h/%b want 00/0", sum, cout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (in_ready2 !== 1'b0 || out_valid2 !== 1'b0) begin failures++; $display("FAIL reset_w2: got rdy=%b vld=%b want 0/0", in_ready2, out_valid2); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b/%b want 1/1", in_ready, in_ready2); end
    endtask

    task automatic test_zero;
        logic [7:0] rs; logic rc; int lat; bit sr;
        op8(8'h00, 8'h00, 1'b0, 0, 0, 1'b0, rs, rc, lat, sr);
        checks++; if (lat !== 8) begin failures++; $display("FAIL zero_latency: got %0d want 8", lat); end
        checks++; if (rs !== 8'h00 || rc !== 1'b0) begin failures++; $display("FAIL zero_result: got %h/%b want 00/0", rs, rc); end
        checks++; if (sr !== 1'b0) begin failures++; $display("FAIL zero_in_ready_busy: got %b want 0", sr); end
    endtask

    task automatic test_carry;
        logic [7:0] rs; logic rc; int lat; bit sr;
        op8(8'hFF, 8'h01, 1'b0, 1, 0, 1'b0, rs, rc, lat, sr);
        checks++; if (rs !== 8'h00 || rc !== 1'b1) begin failures++; $display("FAIL carry_ff_01: got %h/%b want 00/1", rs, rc); end
        op8(8'h5A, 8'hA5, 1'b1, 0, 1, 1'b0, rs, rc, lat, sr);
        checks++; if (rs !== 8'h00 || rc !== 1'b1) begin failures++; $display("FAIL carry_5a_a5_1: got %h/%b want 00/1", rs, rc); end
        op8(8'h0F, 8'h01, 1'b0, 2, 0, 1'b0, rs, rc, lat, sr);
        checks++; if (rs !== 8'h10 || rc !== 1'b0) begin failures++; $display("FAIL carry_0f_01: got %h/%b want 10/0", rs, rc); end
        op8(8'hFF, 8'hFF, 1'b1, 0, 0, 1'b0, rs, rc, lat, sr);
        checks++; if (rs !== 8'hFF || rc !== 1'b1) begin failures++; $display("FAIL wrap_all_ones: got %h/%b want ff/1", rs, rc); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || sum !== 8'h46 || cout !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got vld=%b sum=%h cout=%b rdy=%b want 1/46/0/0", i, out_valid, sum, cout, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
        checks++; if (sum !== 8'h46) begin failures++; $display("FAIL bp_sum_kept: got %h want 46", sum); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_pending_accept: got busy=%b rdy=%b want 1/0", busy, in_ready); end
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || sum !== 8'h00 || cout !== 1'b1) begin failures++; $display("FAIL bp_second_result: got vld=%b %h/%b want 1/00/1", out_valid, sum, cout); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_inflight;
        logic [7:0] rs; logic rc; int lat; bit sr;
        op8(8'h3C, 8'h42, 1'b0, 0, 0, 1'b1, rs, rc, lat, sr);
        checks++; if (rs !== 8'h7E || rc !== 1'b0) begin failures++; $display("FAIL inflight_result: got %h/%b want 7e/0", rs, rc); end
        checks++; if (lat !== 8) begin failures++; $display("FAIL inflight_latency: got %0d want 8", lat); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rs; logic rc; int lat; bit sr;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_state: got vld=%b sum=%h cout=%b busy=%b rdy=%b want 0/00/0/0/0", out_valid, sum, cout, busy, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_mid_ready: got %b want 1", in_ready); end
        op8(8'h01, 8'h01, 1'b0, 0, 0, 1'b0, rs, rc, lat, sr);
        checks++; if (rs !== 8'h02 || rc !== 1'b0) begin failures++; $display("FAIL reset_mid_next: got %h/%b want 02/0", rs, rc); end
    endtask

    task automatic test_random8;
        logic [7:0] ta, tb_, rs; logic tc, rc; logic [8:0] exp_v; int lat; bit sr;
        int results = 0;
        for (int n = 0; n < 500; n++) begin
            ta = 8'($urandom); tb_ = 8'($urandom); tc = 1'($urandom);
            exp_v = {1'b0, ta} + {1'b0, tb_} + {8'h00, tc};
            op8(ta, tb_, tc, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, rs, rc, lat, sr);
            if (lat == 8) results++;
            checks++;
            if ({rc, rs} !== exp_v || lat !== 8 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rand8[%0d] %h+%h+%b: got %h lat=%0d vld=%b want %h lat=8 vld=0", n, ta, tb_, tc, {rc, rs}, lat, out_valid, exp_v);
            end
        end
        checks++; if (results !== 500) begin failures++; $display("FAIL rand8_count: got %0d results want 500", results); end
    endtask

    task automatic test_exhaustive2;
        logic [1:0] rs; logic rc; logic [2:0] exp_v; int lat;
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    exp_v = 3'(ai + bi + ci);
                    op2(2'(ai), 2'(bi), 1'(ci), $urandom_range(0, 2), $urandom_range(0, 2), rs, rc, lat);
                    checks++;
                    if ({rc, rs} !== exp_v || lat !== 2) begin
                        failures++;
                        $display("FAIL w2 %0d+%0d+%0d: got %b lat=%0d want %b lat=2", ai, bi, ci, {rc, rs}, lat, exp_v);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        test_reset;
        test_zero;
        test_carry;
        test_backpressure;
        test_inflight;
        test_reset_mid;
        test_random8;
        test_exhaustive2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
